uart_rx_ovs: RTL and testbench
==============================

UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, sample_tick pulses per bit period; legal values are even numbers 4..32.
REQ-003 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-004 Parameter PARITY_ODD, default 0, parity sense (0 = even, 1 = odd); used only when UART_RX_PARITY_EN is defined.
REQ-005 reset is asynchronous and active-high; clock is the single clock; every register is in the clock domain.
REQ-006 clock  input  1  system clock, rising edge.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 sample_tick  input  1  one-cycle strobe at OVERSAMPLE x baud rate.
REQ-009 rx_in  input  1  asynchronous serial line, idle high.
REQ-010 rx_ready  input  1  consumer accepts rx_data when high together with rx_valid.
REQ-011 rx_data  output  DATA_BITS  received word, LSB first on the line.
REQ-012 rx_valid  output  1  rx_data, frame_err and parity_err are valid; held until accepted.
REQ-013 frame_err  output  1  at least one stop bit of the current word was sampled low.
REQ-014 parity_err  output  1  parity mismatch on the current word; tied 0 without UART_RX_PARITY_EN.
REQ-015 overrun  output  1  one-cycle pulse: a completed word overwrote an unaccepted word.
REQ-016 busy  output  1  state is not IDLE.

Function
REQ-017 rx_in shall pass through a 2-flop synchronizer; all decisions use the synchronized value (rxs).
REQ-018 The block shall implement an FSM with states IDLE, START, DATA, PARITY and STOP, plus a tick counter and a bit counter.
REQ-019 Counters and rxs sampling shall advance only on cycles with sample_tick=1; the FSM shall hold state on all other cycles.
REQ-020 IDLE: on a tick with rxs=0, the FSM shall go to START and clear the tick counter.
REQ-021 START: on tick count OVERSAMPLE/2-1 (mid-bit), rxs=1 shall return the FSM to IDLE (false start, no output); rxs=0 shall go to DATA with the tick and bit counters cleared.
REQ-022 DATA: every OVERSAMPLE ticks the block shall shift rxs in LSB-first; after DATA_BITS samples it shall go to PARITY if UART_RX_PARITY_EN is defined, otherwise to STOP.
REQ-023 PARITY: one mid-bit sample, OVERSAMPLE ticks after the last data sample, then go to STOP.
REQ-024 STOP: STOP_BITS samples spaced OVERSAMPLE ticks; any low sample shall set the pending frame error.
REQ-025 On the tick of the last stop sample, the FSM shall return to IDLE immediately (no wait for end of bit) and the word shall complete.
REQ-026 Completion: in the cycle after the last stop sample, rx_data, frame_err and parity_err shall load and rx_valid shall go to 1.
REQ-027 Latency: rx_valid shall rise 1 clock after the sample_tick of the final stop-bit sample.
REQ-028 rx_valid shall fall in the cycle after the first clock with rx_valid=1 and rx_ready=1; rx_data shall remain stable while rx_valid=1 unless overrun occurs.
REQ-029 Completion while rx_valid=1 and rx_ready=0: the new word shall overwrite the old one, rx_valid shall stay 1 and overrun shall pulse for 1 cycle.
REQ-030 Completion in the same cycle as acceptance (rx_valid=1, rx_ready=1): the new word shall load, rx_valid shall stay 1 and no overrun shall be raised.
REQ-031 Words with frame_err=1 shall still be delivered; a break (line held low) shall yield rx_data=0 with frame_err=1, and the next frame shall start only after rxs is seen high in IDLE.

Reset
REQ-032 Reset shall force the FSM to IDLE, clear all counters, and set the synchronizer flops to 1.
REQ-033 Reset shall set rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0 and busy=0.
REQ-034 Reset asserted mid-frame shall discard the partial word; after reset releases, the block shall wait for a fresh falling edge.

Configuration
REQ-035 Macro UART_RX_PARITY_EN shall control parity support.
REQ-036 With UART_RX_PARITY_EN defined: the frame includes a parity bit; parity_err = XOR(data, parity bit) XOR PARITY_ODD is non-zero.
REQ-037 Without UART_RX_PARITY_EN: there is no PARITY state or parity logic, and parity_err is constant 0.

Verification
REQ-038 Defaults, frame 0x55 with 1 stop bit -> rx_valid=1, rx_data=0x55, frame_err=0, 1 clock after the stop-bit mid-sample tick.
REQ-039 rx_in low for 5 ticks then high (OVERSAMPLE=16) -> return to IDLE, rx_valid stays 0, busy falls.
REQ-040 Frame 0xA3 with the stop bit driven low -> rx_data=0xA3, frame_err=1; the next frame 0x0F is received cleanly with frame_err=0.
REQ-041 rx_ready=0, send 0x11 then 0x22 -> a 1-cycle overrun pulse, rx_data=0x22, rx_valid=1; then rx_ready=1 -> rx_valid=0 on the next clock.
REQ-042 UART_RX_PARITY_EN defined, PARITY_ODD=0, DATA_BITS=7: 0x41 with parity bit 0 -> parity_err=0; the same frame with parity bit 1 -> parity_err=1.
REQ-043 Reset asserted after 4 data bits, then a full frame 0xC6 -> only rx_data=0xC6 is delivered, and no partial word appears.

Source files
------------

// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampled UART receiver (2-flop synced line, mid-bit sampling); define UART_RX_PARITY_EN for a parity bit.
// Latency: rx_valid rises 1 clock after the sample_tick that takes the final stop-bit sample.
// Backpressure: one output word held until rx_ready; a newer word overwrites it and pulses overrun.
module uart_rx_ovs #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx_in,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS);
    localparam logic [TCW-1:0] TICK_MID  = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || OVERSAMPLE > 32 ||
        (OVERSAMPLE % 2) != 0 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
        $error("uart_rx_ovs: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t               state, state_nxt;
    logic                 sync_ff1, rxs;
    logic [TCW-1:0]       tick_cnt, tick_cnt_nxt;
    logic [BCW-1:0]       bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 ferr_pend, ferr_nxt;
    // armed: line has been seen high in IDLE, so a low sample is a genuine falling edge
    logic                 armed, armed_nxt;
    logic                 word_done, done_nxt;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit, par_nxt;
    logic                 perr_calc;
`endif

    assign busy = (state != IDLE);

    // two-flop synchronizer on the raw line; resets to the idle level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_ff1 <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            sync_ff1 <= rx_in;
            rxs      <= sync_ff1;
        end
    end

    // FSM state, counters and shift register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            ferr_pend <= 1'b0;
            armed     <= 1'b0;
            word_done <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            tick_cnt  <= tick_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            ferr_pend <= ferr_nxt;
            armed     <= armed_nxt;
            word_done <= done_nxt;
`ifdef UART_RX_PARITY_EN
            par_bit   <= par_nxt;
`endif
        end
    end

    // next-state logic: everything advances only on sample_tick
    always_comb begin
        state_nxt    = state;
        tick_cnt_nxt = tick_cnt;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        ferr_nxt     = ferr_pend;
        armed_nxt    = armed;
        done_nxt     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_nxt      = par_bit;
`endif
        if (sample_tick) begin
            case (state)
                IDLE: begin
                    if (rxs) begin
                        armed_nxt = 1'b1;
                    end else if (armed) begin
                        state_nxt    = START;
                        tick_cnt_nxt = '0;
                        armed_nxt    = 1'b0;
                    end
                end
                START: begin
                    if (tick_cnt == TICK_MID) begin
                        if (rxs) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt    = DATA;
                            tick_cnt_nxt = '0;
                            bit_cnt_nxt  = '0;
                            ferr_nxt     = 1'b0;
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_nxt = '0;
                        shreg_nxt    = {rxs, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
                            state_nxt   = PARITY;
`else
                            state_nxt   = STOP;
`endif
                        end else begin
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_nxt = '0;
                        par_nxt      = rxs;
                        state_nxt    = STOP;
                    end else begin
                        tick_cnt_nxt = tick_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_cnt_nxt = '0;
                        if (!rxs) begin
                            ferr_nxt = 1'b1;
                        end
                        // leave at the last stop sample so a following start edge is not missed
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt_nxt = '0;
                            state_nxt   = IDLE;
                            done_nxt    = 1'b1;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign perr_calc = (^shreg) ^ par_bit ^ (PARITY_ODD != 0);
`else
    assign parity_err = 1'b0;
`endif

    // output register: load on completion, drop on acceptance, flag overwrite of an unaccepted word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (word_done) begin
                rx_data    <= shreg;
                frame_err  <= ferr_pend;
                rx_valid   <= 1'b1;
                overrun    <= rx_valid & ~rx_ready;
`ifdef UART_RX_PARITY_EN
                parity_err <= perr_calc;
`endif
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// tb_uart_rx_ovs: randomized frames against a frame-level reference model of the receiver.
// Ticks every 4 clocks; the line changes 3 clocks ahead of each tick so the synchronizer settles.
// Expected sample instants are derived from bit positions: start detected on the first low tick.
module tb_uart_rx_ovs;
`ifdef UART_RX_PARITY_EN
    localparam int DB = 7;
    localparam int PB = 1;
`else
    localparam int DB = 8;
    localparam int PB = 0;
`endif
    localparam int OS = 16;
    localparam int SB = 1;
    localparam int PO = 0;
    localparam int NB = 1 + DB + PB + SB;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          sample_tick = 1'b0;
    logic          rx_in = 1'b1;
    logic          rx_ready = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid, frame_err, parity_err, overrun, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ticks = 0;
    int tgt_tick = -1;
    int tgt_cyc = -1;
    int rise_cyc = -1;
    int rises = 0;
    int ovr_cycles = 0;
    logic          vld_prev = 1'b0;
    logic [DB-1:0] got_data = '0;
    logic          got_ferr = 1'b0;
    logic          got_perr = 1'b0;
    bit            ready_on_done = 1'b0;
    bit            ready_pulse = 1'b0;

    uart_rx_ovs #(
        .DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(SB), .PARITY_ODD(PO)
    ) dut (
        .clock(clock), .reset(reset), .sample_tick(sample_tick), .rx_in(rx_in),
        .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
    );

    always #5 clock = ~clock;

    // reference parity rule: XOR of data, parity bit and sense
    function automatic logic exp_perr(input logic [DB-1:0] d, input logic p);
        return (PB == 1) ? ((^d) ^ p ^ (PO != 0)) : 1'b0;
    endfunction

    // one clock; sample outputs 1 time unit after the edge and record deliveries
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (overrun) ovr_cycles++;
        if (rx_valid && !vld_prev) begin
            rise_cyc = cyc;
            rises++;
            got_data = rx_data;
            got_ferr = frame_err;
            got_perr = parity_err;
        end
        vld_prev = rx_valid;
    endtask

    task automatic tick_period();
        sample_tick = 1'b0;
        step();
        if (ready_pulse) begin
            rx_ready = 1'b0;
            ready_pulse = 1'b0;
        end
        step();
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        ticks++;
        if (ticks == tgt_tick) begin
            tgt_cyc = cyc;
            if (ready_on_done) begin
                rx_ready = 1'b1;
                ready_pulse = 1'b1;
            end
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_in = v;
        repeat (OS) tick_period();
    endtask

    // a full frame; the final stop sample sits mid-way through the last bit
    task automatic send_frame(input logic [DB-1:0] d, input bit stop_low, input logic p);
        tgt_tick = ticks + 1 + OS / 2 + OS * (NB - 1);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        if (PB == 1) drive_bit(p);
        for (int j = 0; j < SB; j++) drive_bit(stop_low ? 1'b0 : 1'b1);
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        checks++; if (rx_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", rx_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", parity_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        drive_bit(1'b1);
    endtask

    task automatic test_frames();
        int vals[4] = '{32'h55, 32'h00, 32'hFF, 32'hA5};
        for (int i = 0; i < 14; i++) begin
            logic [DB-1:0] d;
            bit            sl;
            logic          p;
            int            r0;
            if (i < 4) begin
                d  = DB'(vals[i]);
                sl = 1'b0;
            end else begin
                d  = DB'($urandom);
                sl = ($urandom_range(0, 3) == 0);
            end
            p = (PB == 1) ? logic'($urandom_range(0, 1)) : 1'b0;
            repeat ($urandom_range(0, 2)) drive_bit(1'b1);
            r0 = rises;
            send_frame(d, sl, p);
            if (sl) drive_bit(1'b1);
            checks++; if (rises !== r0 + 1) begin errors++; $display("FAIL frame%0d_count: got %0d want %0d", i, rises - r0, 1); end
            checks++; if (rise_cyc !== tgt_cyc + 1) begin errors++; $display("FAIL frame%0d_latency: got cycle %0d want %0d", i, rise_cyc, tgt_cyc + 1); end
            checks++; if (got_data !== d) begin errors++; $display("FAIL frame%0d_data: got %h want %h", i, got_data, d); end
            checks++; if (got_ferr !== sl) begin errors++; $display("FAIL frame%0d_ferr: got %b want %b", i, got_ferr, sl); end
            checks++; if (got_perr !== exp_perr(d, p)) begin errors++; $display("FAIL frame%0d_perr: got %b want %b", i, got_perr, exp_perr(d, p)); end
            checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL frame%0d_accepted: got %b want 0", i, rx_valid); end
        end
    endtask

    task automatic test_false_start();
        int r0 = rises;
        rx_in = 1'b0;
        repeat (5) tick_period();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL false_start_busy_hi: got %b want 1", busy); end
        drive_bit(1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL false_start_busy_lo: got %b want 0", busy); end
        checks++; if (rises !== r0) begin errors++; $display("FAIL false_start_no_word: got %0d words want 0", rises - r0); end
    endtask

    task automatic test_frame_err();
        logic [DB-1:0] a = DB'(32'hA3);
        logic [DB-1:0] b = DB'(32'h0F);
        logic          pa = ^a;
        logic          pb = ^b;
        send_frame(a, 1'b1, pa);
        checks++; if (got_data !== a || got_ferr !== 1'b1) begin errors++; $display("FAIL ferr_word: got %h/%b want %h/1", got_data, got_ferr, a); end
        drive_bit(1'b1);
        send_frame(b, 1'b0, pb);
        checks++; if (got_data !== b || got_ferr !== 1'b0) begin errors++; $display("FAIL ferr_next_word: got %h/%b want %h/0", got_data, got_ferr, b); end
    endtask

    task automatic test_break();
        int            r0 = rises;
        logic [DB-1:0] c = DB'(32'h5A);
        send_frame('0, 1'b1, 1'b0);
        repeat (2) drive_bit(1'b0);
        checks++; if (rises !== r0 + 1) begin errors++; $display("FAIL break_count: got %0d want 1", rises - r0); end
        checks++; if (got_data !== '0 || got_ferr !== 1'b1) begin errors++; $display("FAIL break_word: got %h/%b want 0/1", got_data, got_ferr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_idle: got busy %b want 0", busy); end
        drive_bit(1'b1);
        send_frame(c, 1'b0, ^c);
        checks++; if (got_data !== c || got_ferr !== 1'b0) begin errors++; $display("FAIL break_recover: got %h/%b want %h/0", got_data, got_ferr, c); end
    endtask

    task automatic test_overrun();
        int            o0 = ovr_cycles;
        logic [DB-1:0] a = DB'(32'h11);
        logic [DB-1:0] b = DB'(32'h22);
        rx_ready = 1'b0;
        send_frame(a, 1'b0, ^a);
        checks++; if (rx_valid !== 1'b1 || rx_data !== a) begin errors++; $display("FAIL ovr_first_held: got %b/%h want 1/%h", rx_valid, rx_data, a); end
        send_frame(b, 1'b0, ^b);
        checks++; if (ovr_cycles !== o0 + 1) begin errors++; $display("FAIL ovr_pulse: got %0d cycles want 1", ovr_cycles - o0); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== b) begin errors++; $display("FAIL ovr_overwrite: got %b/%h want 1/%h", rx_valid, rx_data, b); end
        rx_ready = 1'b1;
        step();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept: got %b want 0", rx_valid); end
    endtask

    task automatic test_accept_collision();
        int            o0 = ovr_cycles;
        logic [DB-1:0] a = DB'(32'h3C);
        logic [DB-1:0] b = DB'(32'hC3);
        rx_ready = 1'b0;
        send_frame(a, 1'b0, ^a);
        ready_on_done = 1'b1;
        send_frame(b, 1'b0, ^b);
        ready_on_done = 1'b0;
        checks++; if (ovr_cycles !== o0) begin errors++; $display("FAIL collide_no_ovr: got %0d cycles want 0", ovr_cycles - o0); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== b) begin errors++; $display("FAIL collide_word: got %b/%h want 1/%h", rx_valid, rx_data, b); end
        rx_ready = 1'b1;
        step();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL collide_accept: got %b want 0", rx_valid); end
    endtask

    task automatic test_reset_midframe();
        int            r0 = rises;
        logic [DB-1:0] c = DB'(32'hC6);
        rx_ready = 1'b1;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        reset = 1'b1;
        step();
        checks++; if (busy !== 1'b0 || rx_data !== '0) begin errors++; $display("FAIL rst_mid_clear: got busy %b data %h want 0/0", busy, rx_data); end
        step();
        reset = 1'b0;
        repeat (OS / 2) tick_period();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_wait_edge: got busy %b want 0", busy); end
        drive_bit(1'b1);
        send_frame(c, 1'b0, ^c);
        drive_bit(1'b1);
        checks++; if (rises !== r0 + 1) begin errors++; $display("FAIL rst_mid_count: got %0d words want 1", rises - r0); end
        checks++; if (got_data !== c || got_ferr !== 1'b0) begin errors++; $display("FAIL rst_mid_word: got %h/%b want %h/0", got_data, got_ferr, c); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic [DB-1:0] d = DB'(32'h41);
        send_frame(d, 1'b0, 1'b0);
        checks++; if (got_data !== d || got_perr !== 1'b0) begin errors++; $display("FAIL parity_good: got %h/%b want %h/0", got_data, got_perr, d); end
        send_frame(d, 1'b0, 1'b1);
        checks++; if (got_data !== d || got_perr !== 1'b1) begin errors++; $display("FAIL parity_bad: got %h/%b want %h/1", got_data, got_perr, d); end
    endtask
`endif

    initial begin
        test_reset();
        test_frames();
        test_false_start();
        test_frame_err();
        test_break();
        test_overrun();
        test_accept_collision();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
